// File: rtl/bcd_to_binary.sv
// ============================================================================
// Module   : bcd_to_binary
// Brief    : Sequential 3-digit BCD to 10-bit binary converter using reverse
//            double-dabble (shift right, then -3 on nibbles >= 8), 10 steps.
//            Optional macro BCD_TO_BINARY_RANGE_CHECK_EN flags digits > 9.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_to_binary (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [9:0] binary,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [3:0] C_LAST_ITER = 4'd9;

  state_t      state_q, state_d;
  logic [11:0] bcd_q, bcd_d;
  logic [9:0]  bin_q, bin_d;
  logic [9:0]  binary_q, binary_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        bad_q, bad_d;

  logic [21:0] w_shifted;
  logic [11:0] w_bcd_fixed;
  logic        w_digit_bad;

`ifdef BCD_TO_BINARY_RANGE_CHECK_EN
  assign w_digit_bad = (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);
`else
  assign w_digit_bad = 1'b0;
`endif

  // One reverse double-dabble step: shift right, then pull each nibble
  // that received a carried-in half-ten (>= 8) back down by 3.
  always_comb begin
    w_shifted   = {bcd_q, bin_q} >> 1;
    w_bcd_fixed = w_shifted[21:10];
    for (int i = 0; i < 3; i++) begin
      if (w_shifted[10 + i*4 +: 4] >= 4'd8) begin
        w_bcd_fixed[i*4 +: 4] = w_shifted[10 + i*4 +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    binary_d = binary_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    bad_d    = bad_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d   = {hundreds, tens, ones};
          bin_d   = 10'd0;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          bad_d   = w_digit_bad;
          state_d = w_digit_bad ? FINISH : SHIFT;
        end
      end

      SHIFT: begin
        bcd_d = w_bcd_fixed;
        bin_d = w_shifted[9:0];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == C_LAST_ITER) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        binary_d = bad_q ? 10'd0 : bin_q;
        err_d    = bad_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bcd_q    <= 12'd0;
      bin_q    <= 10'd0;
      binary_q <= 10'd0;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      binary_q <= binary_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      bad_q    <= bad_d;
    end
  end

  assign binary = binary_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_binary.sv
// ============================================================================
// Module   : tb_bcd_to_binary
// Brief    : Self-checking bench for bcd_to_binary: vector table, random
//            digits against an arithmetic model, and handshake corner cases.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_binary;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [9:0] binary;
  logic       busy;
  logic       done;
  logic       err;

  int n_vec;
  int n_fail;

  typedef struct {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    int         exp_bin;
  } vec_t;

  bcd_to_binary dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones),
    .binary   (binary),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model(input int h, input int t, input int o);
    return 100 * h + 10 * t + o;
  endfunction

  // Full handshake: start on one edge, expect done exp_lat cycles later.
  task automatic run_conv(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                          input int exp_bin, input logic exp_err, input int exp_lat,
                          input string nm);
    int  n;
    bit  seen;
    @(negedge clk);
    start = 1'b1; hundreds = h; tens = t; ones = o;
    @(posedge clk); #1;
    start    = 1'b0;
    hundreds = 4'($urandom_range(15));
    tens     = 4'($urandom_range(15));
    ones     = 4'($urandom_range(15));
    chk({nm, " busy_after_start"}, 32'(busy), 32'd1);
    chk({nm, " done_low_at_start"}, 32'(done), 32'd0);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
    end
    chk({nm, " latency"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_lat));
    if (seen) begin
      chk({nm, " binary"}, 32'(binary), 32'(exp_bin));
      chk({nm, " err"}, 32'(err), 32'(exp_err));
      chk({nm, " busy_at_done"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    vec_t tbl[6];
    int   cnt;
    int   first_lat;
    int   h, t, o;

    n_vec  = 0;
    n_fail = 0;
    start  = 1'b0;
    hundreds = 4'd0; tens = 4'd0; ones = 4'd0;
    rst_n  = 1'b0;

    tbl[0] = '{4'd9, 4'd9, 4'd9, 999};
    tbl[1] = '{4'd0, 4'd0, 4'd1, 1};
    tbl[2] = '{4'd5, 4'd1, 4'd2, 512};
    tbl[3] = '{4'd1, 4'd0, 4'd0, 100};
    tbl[4] = '{4'd8, 4'd8, 4'd8, 888};
    tbl[5] = '{4'd0, 4'd9, 4'd0, 90};

    repeat (3) @(posedge clk);
    #1;
    chk("reset binary", 32'(binary), 32'd0);
    chk("reset busy",   32'(busy),   32'd0);
    chk("reset done",   32'(done),   32'd0);
    chk("reset err",    32'(err),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_conv(tbl[i].h, tbl[i].t, tbl[i].o, tbl[i].exp_bin, 1'b0, 11, $sformatf("tbl%0d", i));
    end

    // Reset while idle clears a held nonzero result.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("idle_reset binary", 32'(binary), 32'd0);
    chk("idle_reset busy",   32'(busy),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back: second start lands on the first idle edge after done.
    run_conv(4'd0, 4'd0, 4'd0, 0, 1'b0, 11, "b2b_first");
    run_conv(4'd2, 4'd5, 4'd5, 255, 1'b0, 11, "b2b_second");

    // Start pulsed mid-conversion must be ignored.
    @(negedge clk);
    start = 1'b1; hundreds = 4'd1; tens = 4'd2; ones = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    first_lat = -1;
    for (int c = 1; c <= 26; c++) begin
      if (c == 5) begin
        @(negedge clk);
        start = 1'b1; hundreds = 4'd4; tens = 4'd5; ones = 4'd6;
      end else if (c == 6) begin
        @(negedge clk);
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        cnt++;
        if (first_lat < 0) begin
          first_lat = c;
          chk("ignored_start binary", 32'(binary), 32'd123);
        end
      end
    end
    chk("ignored_start latency", 32'(first_lat), 32'd11);
    chk("ignored_start done_count", 32'(cnt), 32'd1);

    // Reset in flight discards the conversion.
    @(negedge clk);
    start = 1'b1; hundreds = 4'd7; tens = 4'd0; ones = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("flight_reset busy",   32'(busy),   32'd0);
    chk("flight_reset done",   32'(done),   32'd0);
    chk("flight_reset binary", 32'(binary), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    chk("flight_reset no_done", 32'(cnt), 32'd0);
    run_conv(4'd0, 4'd4, 4'd2, 42, 1'b0, 11, "after_reset");

`ifdef BCD_TO_BINARY_RANGE_CHECK_EN
    run_conv(4'd0, 4'hA, 4'd3, 0, 1'b1, 1, "range_bad");
    run_conv(4'd0, 4'd1, 4'd0, 10, 1'b0, 11, "range_recover");
`endif

    for (int i = 0; i < 20; i++) begin
      h = $urandom_range(9);
      t = $urandom_range(9);
      o = $urandom_range(9);
      run_conv(4'(h), 4'(t), 4'(o), model(h, t, o), 1'b0, 11, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
